// File: rtl/interface_hcsr04_pkg.sv
// rtl/interface_hcsr04_pkg.sv - shared states, constants and BCD helper for the HC-SR04 interface
package interface_hcsr04_pkg;

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        PREPARACAO    = 4'h1,
        ENVIA_TRIGGER = 4'h2,
        ESPERA_ECHO   = 4'h3,
        MEDINDO       = 4'h4,
        ARMAZENA      = 4'h5,
        FINAL         = 4'h6,
        ERRO          = 4'hF
    } estado_t;

    localparam int LARGURA_TRIGGER_PADRAO = 500;
    localparam int CICLOS_CM_PADRAO       = 2941;
    localparam int TIMEOUT_CICLOS_PADRAO  = 1_250_000;

    localparam logic [11:0] BCD_MAX     = 12'h999;
    localparam logic [11:0] ERRO_MEDIDA = 12'hFFF;

    // Decimal increment of a 3-digit BCD value, holding at 999.
    function automatic logic [11:0] bcd_incrementa(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v != BCD_MAX) begin
            if (v[3:0] == 4'd9) begin
                r[3:0] = 4'd0;
                if (v[7:4] == 4'd9) begin
                    r[7:4]  = 4'd0;
                    r[11:8] = v[11:8] + 4'd1;
                end else begin
                    r[7:4] = v[7:4] + 4'd1;
                end
            end else begin
                r[3:0] = v[3:0] + 4'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/interface_hcsr04_contador_cm_bcd.sv
// rtl/interface_hcsr04_contador_cm_bcd.sv - echo-cycle prescaler feeding a saturating 3-digit BCD cm counter
module contador_cm_bcd
    import interface_hcsr04_pkg::*;
#(
    parameter int CICLOS_CM = CICLOS_CM_PADRAO
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        zera,
    input  logic        conta,
    output logic [11:0] bcd,
    output logic        meia
);

    localparam int CW = $clog2(CICLOS_CM);

    logic [CW-1:0] ciclos;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ciclos <= '0;
            bcd    <= 12'h000;
        end else if (zera) begin
            ciclos <= '0;
            bcd    <= 12'h000;
        end else if (conta) begin
            if (ciclos == CW'(CICLOS_CM - 1)) begin
                ciclos <= '0;
                bcd    <= bcd_incrementa(bcd);
            end else begin
                ciclos <= ciclos + CW'(1);
            end
        end
    end

    // Residual of at least half a centimetre rounds the result up.
    assign meia = (ciclos >= CW'(CICLOS_CM / 2));

endmodule

// File: rtl/interface_hcsr04.sv
// rtl/interface_hcsr04.sv - HC-SR04 trigger/echo timer to BCD cm; INTERFACE_HCSR04_TIMEOUT_EN adds echo timeout
module interface_hcsr04
    import interface_hcsr04_pkg::*;
#(
    parameter int CLK_HZ          = 50_000_000,
    parameter int LARGURA_TRIGGER = LARGURA_TRIGGER_PADRAO,
    parameter int CICLOS_CM       = CICLOS_CM_PADRAO,
    parameter int TIMEOUT_CICLOS  = TIMEOUT_CICLOS_PADRAO
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        medir,
    input  logic        echo,
    output logic        trigger,
    output logic [11:0] medida,
    output logic        pronto,
    output logic        erro,
    output logic [3:0]  db_estado
);

    localparam int TW = $clog2(LARGURA_TRIGGER + 1);
    localparam int unused_cfg = CLK_HZ + TIMEOUT_CICLOS;

    estado_t       estado;
    logic [TW-1:0] cnt_trig;
    logic          echo_s1, echo_s2, echo_ant;
    logic          sobe, desce;
    logic [11:0]   bcd;
    logic          meia;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            echo_s1  <= 1'b0;
            echo_s2  <= 1'b0;
            echo_ant <= 1'b0;
        end else begin
            echo_s1  <= echo;
            echo_s2  <= echo_s1;
            echo_ant <= echo_s2;
        end
    end

    assign sobe  = echo_s2 & ~echo_ant;
    assign desce = ~echo_s2 & echo_ant;

    contador_cm_bcd #(
        .CICLOS_CM(CICLOS_CM)
    ) u_contador (
        .clock (clock),
        .reset (reset),
        .zera  (estado == PREPARACAO),
        .conta (estado == MEDINDO),
        .bcd   (bcd),
        .meia  (meia)
    );

`ifdef INTERFACE_HCSR04_TIMEOUT_EN
    localparam int MW = $clog2(TIMEOUT_CICLOS + 1);
    logic [MW-1:0] cnt_tmo;
    logic          tmo_esgotado;
    assign tmo_esgotado = (cnt_tmo == MW'(TIMEOUT_CICLOS - 1));
`else
    assign erro = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado   <= INICIAL;
            trigger  <= 1'b0;
            medida   <= 12'h000;
            pronto   <= 1'b0;
            cnt_trig <= '0;
`ifdef INTERFACE_HCSR04_TIMEOUT_EN
            erro     <= 1'b0;
            cnt_tmo  <= '0;
`endif
        end else begin
`ifdef INTERFACE_HCSR04_TIMEOUT_EN
            if (estado == ESPERA_ECHO || estado == MEDINDO)
                cnt_tmo <= cnt_tmo + MW'(1);
`endif
            case (estado)
                INICIAL: begin
                    if (medir)
                        estado <= PREPARACAO;
                end
                PREPARACAO: begin
                    cnt_trig <= '0;
                    trigger  <= 1'b1;
                    estado   <= ENVIA_TRIGGER;
`ifdef INTERFACE_HCSR04_TIMEOUT_EN
                    cnt_tmo  <= '0;
                    erro     <= 1'b0;
`endif
                end
                ENVIA_TRIGGER: begin
                    if (cnt_trig == TW'(LARGURA_TRIGGER - 1)) begin
                        trigger <= 1'b0;
                        estado  <= ESPERA_ECHO;
                    end else begin
                        cnt_trig <= cnt_trig + TW'(1);
                    end
                end
                ESPERA_ECHO, MEDINDO: begin
                    if (estado == ESPERA_ECHO && sobe)
                        estado <= MEDINDO;
                    else if (estado == MEDINDO && desce)
                        estado <= ARMAZENA;
`ifdef INTERFACE_HCSR04_TIMEOUT_EN
                    else if (tmo_esgotado) begin
                        estado <= ERRO;
                        medida <= ERRO_MEDIDA;
                        erro   <= 1'b1;
                        pronto <= 1'b1;
                    end
`endif
                end
                ARMAZENA: begin
                    medida <= meia ? bcd_incrementa(bcd) : bcd;
                    pronto <= 1'b1;
                    estado <= FINAL;
                end
                default: begin
                    // FINAL and ERRO both close the one-cycle pronto pulse.
                    pronto <= 1'b0;
                    estado <= INICIAL;
                end
            endcase
        end
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_interface_hcsr04.sv
// tb/tb_interface_hcsr04.sv - randomized self-checking bench for interface_hcsr04 with scaled timing
module tb_interface_hcsr04;

    localparam int L   = 10;
    localparam int C   = 20;
    localparam int TMO = 3000;

    logic        clock = 1'b0;
    logic        reset, medir, echo;
    logic        trigger, pronto, erro;
    logic [11:0] medida;
    logic [3:0]  db_estado;

    int checks = 0;
    int failures = 0;
    int ntrig = 0;
    int npronto = 0;

    always #5 clock = ~clock;

    interface_hcsr04 #(
        .CLK_HZ          (50_000_000),
        .LARGURA_TRIGGER (L),
        .CICLOS_CM       (C),
        .TIMEOUT_CICLOS  (TMO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .medir     (medir),
        .echo      (echo),
        .trigger   (trigger),
        .medida    (medida),
        .pronto    (pronto),
        .erro      (erro),
        .db_estado (db_estado)
    );

    always @(negedge clock) begin
        if (trigger) ntrig++;
        if (pronto)  npronto++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Echo width in cycles -> rounded, saturated centimetres as BCD.
    function automatic logic [11:0] modelo(input int n);
        int cm;
        cm = n / C;
        if ((n % C) >= C / 2) cm++;
        if (cm > 999) cm = 999;
        return {4'(cm / 100), 4'((cm / 10) % 10), 4'(cm % 10)};
    endfunction

    task automatic mede(input int n, input bit extra);
        int t0, p0, k;
        logic [11:0] esp;
        esp = modelo(n);
        t0 = ntrig;
        p0 = npronto;
        @(negedge clock) medir = 1'b1;
        @(negedge clock) medir = 1'b0;
        check("estado_prep", 32'(db_estado), 1);
        @(negedge clock);
        check("estado_trig", 32'(db_estado), 2);
        k = 0;
        while (trigger && k < 1000) begin
            k++;
            medir = extra && (k == 3);
            @(negedge clock);
        end
        medir = 1'b0;
        check("trig_largura", k, L);
        check("estado_espera", 32'(db_estado), 3);
        @(negedge clock) echo = 1'b1;
        for (int i = 0; i < n; i++) begin
            medir = extra && (i == n / 2);
            @(negedge clock);
        end
        medir = 1'b0;
        echo  = 1'b0;
        k = 0;
        while (k < 50) begin
            @(negedge clock);
            k++;
            if (pronto) break;
        end
        check("latencia_pronto", k, 4);
        check("medida", 32'(medida), 32'(esp));
        check("erro_zero", 32'(erro), 0);
        @(negedge clock);
        check("pronto_unico", 32'(pronto), 0);
        check("estado_ini", 32'(db_estado), 0);
        repeat (5) @(negedge clock);
        check("n_pronto", npronto - p0, 1);
        check("n_trigger", ntrig - t0, L);
    endtask

    initial begin
        int k;
        reset = 1'b1;
        medir = 1'b0;
        echo  = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_trigger", 32'(trigger), 0);
        check("rst_medida", 32'(medida), 0);
        check("rst_pronto", 32'(pronto), 0);
        check("rst_erro", 32'(erro), 0);
        check("rst_estado", 32'(db_estado), 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        mede(10 * C, 1'b0);
        mede(10 * C + C / 2, 1'b0);
        mede(10 * C + C / 2 - 1, 1'b0);
        mede(1005 * C, 1'b0);
        mede(7 * C, 1'b0);
        mede(10 * C + 5, 1'b1);
        for (int r = 0; r < 8; r++)
            mede(int'($urandom_range(1, 1200)), 1'(r % 2));

        // Reset while measuring an echo.
        @(negedge clock) medir = 1'b1;
        @(negedge clock) medir = 1'b0;
        k = 0;
        while (db_estado != 4'd3 && k < 1000) begin
            @(negedge clock);
            k++;
        end
        check("espera_antes_reset", 32'(db_estado), 3);
        echo = 1'b1;
        repeat (60) @(negedge clock);
        check("estado_medindo", 32'(db_estado), 4);
        reset = 1'b1;
        #1;
        check("rstm_trigger", 32'(trigger), 0);
        check("rstm_medida", 32'(medida), 0);
        check("rstm_estado", 32'(db_estado), 0);
        @(negedge clock);
        reset = 1'b0;
        echo  = 1'b0;
        repeat (4) @(negedge clock);
        mede(7 * C, 1'b0);

        // Reset while the trigger pulse is high.
        @(negedge clock) medir = 1'b1;
        @(negedge clock) medir = 1'b0;
        repeat (3) @(negedge clock);
        check("trigger_ativo", 32'(trigger), 1);
        reset = 1'b1;
        #1;
        check("rstt_trigger", 32'(trigger), 0);
        check("rstt_estado", 32'(db_estado), 0);
        @(negedge clock) reset = 1'b0;
        repeat (2) @(negedge clock);
        mede(int'($urandom_range(C, 40 * C)), 1'b0);

`ifdef INTERFACE_HCSR04_TIMEOUT_EN
        @(negedge clock) medir = 1'b1;
        @(negedge clock) medir = 1'b0;
        k = 0;
        while (!pronto && k < L + TMO + 100) begin
            @(negedge clock);
            k++;
        end
        check("tmo_pronto", 32'(pronto), 1);
        check("tmo_medida", 32'(medida), 32'hFFF);
        check("tmo_erro", 32'(erro), 1);
        @(negedge clock);
        check("tmo_pronto_fim", 32'(pronto), 0);
        check("tmo_erro_mantido", 32'(erro), 1);
        check("tmo_estado_ini", 32'(db_estado), 0);
        repeat (3) @(negedge clock);
        mede(42 * C, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
